intc_sched: RTL



---
 rtl/intc_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/intc_sched.sv
// intc_sched: four-line interrupt scheduler feeding the PC mux and the return stack.
// Edge-detects and latches requests, masks and prioritises them (line 1 highest),
// then sequences push -> jump at an instruction boundary and tracks in-service levels.
// Optional feature: define INTC_NESTING_EN to allow higher-priority preemption in SERVICE.
module intc_sched #(
  parameter int unsigned      PCW  = 10,
  parameter logic [PCW-1:0]   VEC1 = 10'b1111111011,
  parameter logic [PCW-1:0]   VEC2 = 10'b1111111110,
  parameter logic [PCW-1:0]   VEC3 = 10'b1111111101,
  parameter logic [PCW-1:0]   VEC4 = 10'b1111111100
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     irq,
  input  logic           mask_we,
  input  logic [3:0]     mask_d,
  input  logic           instr_done,
  input  logic [PCW-1:0] pc_in,
  input  logic           reti,
  output logic           push,
  output logic [PCW-1:0] push_data,
  output logic           pop,
  output logic           take_int,
  output logic [PCW-1:0] vector,
  output logic [3:0]     pending,
  output logic [3:0]     in_service,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUSH,
    ST_JUMP,
    ST_SERVICE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     irq_prev_q, irq_prev_d;
  logic [3:0]     enable_mask_q, enable_mask_d;
  logic [3:0]     pending_q, pending_d;
  logic [3:0]     in_service_q, in_service_d;
  logic [1:0]     winner_q, winner_d;
  logic [PCW-1:0] ret_addr_q, ret_addr_d;
  logic [PCW-1:0] vector_q, vector_d;
  logic           pop_q, pop_d;

  logic [3:0]     irq_rise;
  logic [3:0]     pend_clr;
  logic [3:0]     allowed;
  logic [3:0]     eligible;
  logic [3:0]     svc_top_oh;
  logic [1:0]     win_idx;
  logic           blocked;
  logic           svc_found;

  function automatic logic [PCW-1:0] vec_of(input logic [1:0] idx);
    case (idx)
      2'd0:    vec_of = VEC1;
      2'd1:    vec_of = VEC2;
      2'd2:    vec_of = VEC3;
      default: vec_of = VEC4;
    endcase
  endfunction

  // Arbitration: only levels above the highest in-service level compete; lowest index wins
  always_comb begin
    blocked    = 1'b0;
    svc_found  = 1'b0;
    allowed    = '0;
    svc_top_oh = '0;
    win_idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      blocked    = blocked | in_service_q[i];
      allowed[i] = ~blocked;
      if (in_service_q[i] && !svc_found) begin
        svc_top_oh[i] = 1'b1;
        svc_found     = 1'b1;
      end
    end
    eligible = pending_q & enable_mask_q & allowed;
    for (int unsigned i = 4; i > 0; i--) begin
      if (eligible[i-1]) win_idx = 2'(i - 1);
    end
  end

  // Sequencer: accept at a boundary, push return address, jump, then service until reti
  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    ret_addr_d   = ret_addr_q;
    vector_d     = vector_q;
    in_service_d = in_service_q;
    pop_d        = 1'b0;
    pend_clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (instr_done && (|eligible)) begin
          winner_d   = win_idx;
          ret_addr_d = pc_in;
          state_d    = ST_PUSH;
        end
      end
      ST_PUSH: begin
        pend_clr[winner_q] = 1'b1;
        vector_d           = vec_of(winner_q);
        state_d            = ST_JUMP;
      end
      ST_JUMP: begin
        in_service_d[winner_q] = 1'b1;
        state_d                = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (reti && (|in_service_q)) begin
          in_service_d = in_service_q & ~svc_top_oh;
          pop_d        = 1'b1;
          if ((in_service_q & ~svc_top_oh) == '0) state_d = ST_IDLE;
        end
`ifdef INTC_NESTING_EN
        // reti takes precedence so a preempting push can never land on the pop cycle
        else if (instr_done && (|eligible)) begin
          winner_d   = win_idx;
          ret_addr_d = pc_in;
          state_d    = ST_PUSH;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latching and mask load; a new edge beats a same-cycle clear
  always_comb begin
    irq_prev_d    = irq;
    irq_rise      = irq & ~irq_prev_q;
    pending_d     = (pending_q & ~pend_clr) | irq_rise;
    enable_mask_d = mask_we ? mask_d : enable_mask_q;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      irq_prev_q    <= '0;
      enable_mask_q <= '0;
      pending_q     <= '0;
      in_service_q  <= '0;
      winner_q      <= '0;
      ret_addr_q    <= '0;
      vector_q      <= '0;
      pop_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      irq_prev_q    <= irq_prev_d;
      enable_mask_q <= enable_mask_d;
      pending_q     <= pending_d;
      in_service_q  <= in_service_d;
      winner_q      <= winner_d;
      ret_addr_q    <= ret_addr_d;
      vector_q      <= vector_d;
      pop_q         <= pop_d;
    end
  end

  assign push       = (state_q == ST_PUSH);
  assign take_int   = (state_q == ST_JUMP);
  assign busy       = (state_q == ST_PUSH) || (state_q == ST_JUMP);
  assign push_data  = ret_addr_q;
  assign pop        = pop_q;
  assign vector     = vector_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule
